csr_unit: RTL and testbench
===========================

// Module: csr_unit
// PURPOSE
//  Machine-mode CSR file and trap sequencer. Sits directly downstream of the instruction controller.
//  Consumes csr_reg_rd / csr_reg_wr / check_mret. Produces epc_taken / epc to redirect the PC mux.
//  Holds mstatus, mie, mip, mtvec, mepc and mcause, and sequences timer-interrupt entry and mret return.
// PARAMETERS
//  XLEN       32            data/address width
//  CAUSE_TMR  32'h8000_0007 mcause value written on timer-interrupt entry
// PORTS
//  clk         in   1     system clock, all state on posedge
//  rst         in   1     synchronous, active-high reset
//  pc          in   XLEN  PC of the instruction currently in this stage
//  addr        in   12    CSR address, inst[31:20]
//  wdata       in   XLEN  CSR write data (rs1 value)
//  csr_reg_rd  in   1     CSR read strobe (csrrw)
//  csr_reg_wr  in   1     CSR write strobe
//  check_mret  in   1     current instruction is mret
//  intr        in   1     timer interrupt request; level, asynchronous to pipeline
//  rdata       out  XLEN  CSR read data
//  epc         out  XLEN  redirect target, valid while epc_taken=1
//  epc_taken   out  1     one-cycle PC redirect request
// BEHAVIOUR
//  Map:
//   0x300 mstatus: only MIE[3] and MPIE[7] are stored; other bits read 0.
//   0x304 mie: only MTIE[7] is stored.
//   0x305 mtvec, 0x341 mepc (bits[1:0] forced 0), 0x342 mcause: full width.
//   0x344 mip: read-only; MTIP[7] = synchronised intr.
//   Unmapped address: read 0, write ignored.
//  Read: combinational. rdata = csr[addr] when csr_reg_rd=1, else 0.
//  Write: at posedge when csr_reg_wr=1. A write to mip is ignored.
//  Sync: intr passes through 2 flops (sync1, sync2). mip.MTIP = sync2.
//  FSM, states RUN / TRAP / RET:
//   RUN -> TRAP when sync2 & MTIE & MIE & !check_mret. At that edge:
//    mepc <= pc; mcause <= CAUSE_TMR; MPIE <= MIE; MIE <= 0.
//   RUN -> RET when check_mret. At that edge: MIE <= MPIE; MPIE <= 1.
//   TRAP and RET both -> RUN unconditionally after 1 cycle.
//   No trap is accepted while in TRAP or RET.
//  Outputs (registered): epc_taken=1 exactly in TRAP/RET, 0 otherwise.
//   TRAP: epc = trap target (see CONFIGURATION). RET: epc = mepc. RUN: epc = 0.
//   Latency: 1 cycle from the accepting edge to epc_taken high.
//  Simultaneous events:
//   mret with a pending interrupt: mret wins; the interrupt is re-evaluated in RUN after MIE is restored.
//   CSR write and trap entry on the same edge: the write is applied, but trap updates win on mstatus/mepc/mcause.
//   A CSR write in TRAP/RET is applied normally.
//  Reset: every CSR, both sync flops, rdata path state, epc and epc_taken = 0; FSM = RUN.
//   rst mid-TRAP/RET aborts the redirect; epc_taken=0 on the next cycle.
// CONFIGURATION
//  CSR_VECTORED_EN defined:
//   mtvec[0] is stored (mode); mtvec[1] is forced 0.
//   Mode 1: trap target = {mtvec[31:2],2'b00} + 4*mcause[30:0] (timer: base+0x1C).
//   Mode 0: trap target = base.
//  CSR_VECTORED_EN undefined:
//   mtvec[1:0] is forced 00 on write.
//   Trap target = {mtvec[31:2],2'b00} always.
// TESTING
//  T1 rst=1 for 2 cycles, then read 0x300/0x304/0x305/0x341/0x342 -> all 0; epc_taken=0.
//  T2 write mtvec=0x0000_0103, then read -> 0x100 (macro off) or 0x101 (macro on); read 0x7FF -> 0.
//  T3 set mstatus=0x8 and mie=0x80, mtvec=0x100; raise intr with pc=0x40
//     -> epc_taken pulse 3 cycles later (2 sync + 1), epc=0x100;
//        mepc=0x40, mcause=0x8000_0007, mstatus=0x80.
//  T4 after T3, check_mret=1 -> next cycle epc_taken=1, epc=0x40; mstatus=0x88.
//  T5 MIE=0 with intr high for 10 cycles -> no epc_taken; mip reads 0x80.
//  T6 macro on, mtvec=0x101, repeat T3 -> epc=0x11C.
//  T7 rst asserted in the TRAP cycle -> epc_taken=0 next cycle; all CSRs 0.

Source files
------------

// File: rtl/csr_unit_if.sv
// Purpose: bundles the CSR access, mret/interrupt inputs and PC redirect outputs of csr_unit.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; all strobes are single-cycle and are always accepted.
interface csr_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc;
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
    logic            csr_reg_rd;
    logic            csr_reg_wr;
    logic            check_mret;
    logic            intr;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] epc;
    logic            epc_taken;

    // Instruction controller side: drives strobes, consumes read data and redirect.
    modport master (
        output pc, addr, wdata, csr_reg_rd, csr_reg_wr, check_mret, intr,
        input  rdata, epc, epc_taken
    );

    // CSR unit side.
    modport slave (
        input  pc, addr, wdata, csr_reg_rd, csr_reg_wr, check_mret, intr,
        output rdata, epc, epc_taken
    );
endinterface

// File: rtl/csr_unit.sv
// Purpose: machine-mode CSR file (mstatus/mie/mip/mtvec/mepc/mcause) plus timer-trap / mret sequencer.
// Latency: reads combinational; epc_taken rises 1 cycle after the accepting edge (intr adds 2 sync cycles).
// Backpressure: none; every strobe is consumed in the cycle it is presented.
// Optional feature: CSR_VECTORED_EN enables vectored mtvec mode (mtvec[0] stored, target = base + 4*cause).
module csr_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] CAUSE_TMR = 32'h8000_0007
) (
    input  logic        clk,
    input  logic        rst,
    csr_unit_if.slave   bus
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            take_trap;
    logic            take_ret;

    // Architectural state: only the implemented bits of mstatus/mie are kept.
    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic            mie_mtie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic            sync1;
    logic            sync2;

    logic [XLEN-1:0] rdata_c;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] epc_q;
    logic            epc_taken_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: mret has priority over a pending interrupt; TRAP/RET last exactly one cycle.
    always_comb begin
        state_nxt = state;
        take_trap = 1'b0;
        take_ret  = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.check_mret) begin
                    take_ret  = 1'b1;
                    state_nxt = ST_RET;
                end else if (sync2 && mie_mtie && mstatus_mie) begin
                    take_trap = 1'b1;
                    state_nxt = ST_TRAP;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Trap target; the cause is known to be the timer cause, so use it directly
    // rather than the mcause value being written on the same edge.
    always_comb begin
        trap_base   = {mtvec[XLEN-1:2], 2'b00};
        trap_target = trap_base;
`ifdef CSR_VECTORED_EN
        if (mtvec[0]) begin
            trap_target = trap_base + {CAUSE_TMR[XLEN-3:0], 2'b00};
        end
`endif
    end

    // CSR storage and interrupt synchroniser; trap/mret updates are applied after
    // the software write so they win on mstatus/mepc/mcause.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mtvec        <= '0;
            mepc         <= '0;
            mcause       <= '0;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
        end else begin
            sync1 <= bus.intr;
            sync2 <= sync1;
            if (bus.csr_reg_wr) begin
                case (bus.addr)
                    ADDR_MSTATUS: begin
                        mstatus_mie  <= bus.wdata[3];
                        mstatus_mpie <= bus.wdata[7];
                    end
                    ADDR_MIE:    mie_mtie <= bus.wdata[7];
`ifdef CSR_VECTORED_EN
                    ADDR_MTVEC:  mtvec <= {bus.wdata[XLEN-1:2], 1'b0, bus.wdata[0]};
`else
                    ADDR_MTVEC:  mtvec <= {bus.wdata[XLEN-1:2], 2'b00};
`endif
                    ADDR_MEPC:   mepc   <= {bus.wdata[XLEN-1:2], 2'b00};
                    ADDR_MCAUSE: mcause <= bus.wdata;
                    default: ;
                endcase
            end
            if (take_trap) begin
                mepc         <= {bus.pc[XLEN-1:2], 2'b00};
                mcause       <= CAUSE_TMR;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (take_ret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

    // Combinational read mux; unmapped or idle reads return zero.
    always_comb begin
        rdata_c = '0;
        if (bus.csr_reg_rd) begin
            case (bus.addr)
                ADDR_MSTATUS: begin
                    rdata_c[3] = mstatus_mie;
                    rdata_c[7] = mstatus_mpie;
                end
                ADDR_MIE:    rdata_c[7] = mie_mtie;
                ADDR_MTVEC:  rdata_c    = mtvec;
                ADDR_MEPC:   rdata_c    = mepc;
                ADDR_MCAUSE: rdata_c    = mcause;
                ADDR_MIP:    rdata_c[7] = sync2;
                default:     rdata_c    = '0;
            endcase
        end
    end

    // Registered redirect: high for exactly the TRAP/RET cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc_taken_q <= 1'b0;
            epc_q       <= '0;
        end else begin
            epc_taken_q <= take_trap || take_ret;
            if (take_trap) begin
                epc_q <= trap_target;
            end else if (take_ret) begin
                epc_q <= mepc;
            end else begin
                epc_q <= '0;
            end
        end
    end

    assign bus.rdata     = rdata_c;
    assign bus.epc       = epc_q;
    assign bus.epc_taken = epc_taken_q;
endmodule

// File: tb/tb_csr_unit.sv
// Purpose: scoreboard bench for csr_unit: reads and redirects are queued at issue time and checked by a monitor.
// Latency: reads checked in their own cycle; redirects checked against the exact expected cycle.
// Backpressure: none.
module tb_csr_unit;
    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] val;
    } ep_exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    bit   mon_en;
    bit   done;

    rd_exp_t rd_q[$];
    ep_exp_t ep_q[$];

    csr_unit_if #(.XLEN(32)) bus();

    csr_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_taken;
            exp_taken = (ep_q.size() > 0) && (ep_q[0].cyc == cyc);
            checks++;
            if (bus.epc_taken !== exp_taken) begin
                failures++;
                $display("FAIL epc_taken cyc=%0d got=%b exp=%b", cyc, bus.epc_taken, exp_taken);
            end
            if (exp_taken) begin
                ep_exp_t e;
                e = ep_q.pop_front();
                if (bus.epc_taken === 1'b1) begin
                    checks++;
                    if (bus.epc !== e.val) begin
                        failures++;
                        $display("FAIL %s epc got=%h exp=%h", e.name, bus.epc, e.val);
                    end
                end
            end
            if (bus.csr_reg_rd === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_read addr=%h got=%h exp=none", bus.addr, bus.rdata);
                end else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    if (bus.rdata !== r.val) begin
                        failures++;
                        $display("FAIL %s rdata got=%h exp=%h", r.name, bus.rdata, r.val);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        bus.addr       = a;
        bus.wdata      = d;
        bus.csr_reg_wr = 1'b1;
        tick();
        bus.csr_reg_wr = 1'b0;
    endtask

    task automatic csr_rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        rd_exp_t r;
        r.name = name;
        r.val  = exp;
        rd_q.push_back(r);
        bus.addr       = a;
        bus.csr_reg_rd = 1'b1;
        tick();
        bus.csr_reg_rd = 1'b0;
    endtask

    // Raise intr now and expect the redirect after 2 sync cycles plus the trap edge.
    task automatic fire_trap(input logic [31:0] exp_epc, input string name);
        ep_exp_t e;
        e.name = name;
        e.cyc  = cyc + 3;
        e.val  = exp_epc;
        ep_q.push_back(e);
        bus.intr = 1'b1;
        ticks(3);
    endtask

    logic [31:0] exp_mtvec_103;
    logic [31:0] exp_vec_epc;

    initial begin
`ifdef CSR_VECTORED_EN
        exp_mtvec_103 = 32'h0000_0101;
        exp_vec_epc   = 32'h0000_011C;
`else
        exp_mtvec_103 = 32'h0000_0100;
        exp_vec_epc   = 32'h0000_0100;
`endif
        cyc            = 0;
        checks         = 0;
        failures       = 0;
        mon_en         = 1'b0;
        done           = 1'b0;
        rst            = 1'b1;
        bus.pc         = 32'h0000_0040;
        bus.addr       = '0;
        bus.wdata      = '0;
        bus.csr_reg_rd = 1'b0;
        bus.csr_reg_wr = 1'b0;
        bus.check_mret = 1'b0;
        bus.intr       = 1'b0;

        // T1: reset state
        ticks(2);
        rst    = 1'b0;
        mon_en = 1'b1;
        csr_rd(12'h300, 32'h0, "t1_mstatus");
        csr_rd(12'h304, 32'h0, "t1_mie");
        csr_rd(12'h305, 32'h0, "t1_mtvec");
        csr_rd(12'h341, 32'h0, "t1_mepc");
        csr_rd(12'h342, 32'h0, "t1_mcause");

        // T2: mtvec low-bit masking, unmapped read, mip read-only, mepc alignment
        csr_wr(12'h305, 32'h0000_0103);
        csr_rd(12'h305, exp_mtvec_103, "t2_mtvec");
        csr_rd(12'h7FF, 32'h0, "t2_unmapped");
        csr_wr(12'h344, 32'hFFFF_FFFF);
        csr_rd(12'h344, 32'h0, "t2_mip_ro");
        csr_wr(12'h341, 32'h0000_0043);
        csr_rd(12'h341, 32'h0000_0040, "t2_mepc_align");

        // T3: timer trap entry
        csr_wr(12'h300, 32'h0000_0008);
        csr_wr(12'h304, 32'h0000_0080);
        csr_wr(12'h305, 32'h0000_0100);
        fire_trap(32'h0000_0100, "t3_trap");
        tick();
        csr_rd(12'h341, 32'h0000_0040, "t3_mepc");
        csr_rd(12'h342, 32'h8000_0007, "t3_mcause");
        csr_rd(12'h300, 32'h0000_0080, "t3_mstatus");
        bus.intr = 1'b0;
        ticks(3);

        // T4: mret returns to mepc and restores MIE
        begin
            ep_exp_t e;
            e.name = "t4_mret";
            e.cyc  = cyc + 1;
            e.val  = 32'h0000_0040;
            ep_q.push_back(e);
        end
        bus.check_mret = 1'b1;
        tick();
        bus.check_mret = 1'b0;
        tick();
        csr_rd(12'h300, 32'h0000_0088, "t4_mstatus");

        // T5: interrupt masked by MIE=0; mip still reflects it
        csr_wr(12'h300, 32'h0000_0000);
        bus.intr = 1'b1;
        ticks(10);
        csr_rd(12'h344, 32'h0000_0080, "t5_mip");
        bus.intr = 1'b0;
        ticks(3);

        // T6: vectored mtvec (direct target when the feature is absent)
        csr_wr(12'h305, 32'h0000_0101);
        csr_wr(12'h300, 32'h0000_0008);
        fire_trap(exp_vec_epc, "t6_vec_trap");
        tick();
        bus.intr = 1'b0;
        ticks(3);
        csr_rd(12'h342, 32'h8000_0007, "t6_mcause");

        // T7: reset during the TRAP cycle
        csr_wr(12'h300, 32'h0000_0008);
        fire_trap(exp_vec_epc, "t7_trap");
        rst      = 1'b1;
        bus.intr = 1'b0;
        ticks(2);
        rst = 1'b0;
        ticks(2);
        csr_rd(12'h300, 32'h0, "t7_mstatus");
        csr_rd(12'h304, 32'h0, "t7_mie");
        csr_rd(12'h305, 32'h0, "t7_mtvec");
        csr_rd(12'h341, 32'h0, "t7_mepc");
        csr_rd(12'h342, 32'h0, "t7_mcause");
        csr_rd(12'h344, 32'h0, "t7_mip");
        ticks(3);

        mon_en = 1'b0;
        while (ep_q.size() > 0) begin
            ep_exp_t e;
            e = ep_q.pop_front();
            failures++;
            $display("FAIL %s redirect never checked exp=%h", e.name, e.val);
        end
        while (rd_q.size() > 0) begin
            rd_exp_t r;
            r = rd_q.pop_front();
            failures++;
            $display("FAIL %s read never checked exp=%h", r.name, r.val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        done = 1'b1;
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout cyc=%0d exp=finished", cyc);
            $fatal(1, "timeout");
        end
    end
endmodule
